neopix_serializer: RTL

NEOPIX_SERIALIZER -- requirements
Module: neopix_serializer

---
 rtl/neopix_serializer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/neopix_serializer.sv
// NeoPixel (WS2812-style) frame serializer.
// Fetches one 24-bit colour per pixel from an upstream table, applies a
// global brightness scale, and shifts the pixels out G/R/B MSB-first as
// pulse-width coded bits. A low latch period follows each frame.
//
// Handshake to the colour table: o_addr is a registered index; the table
// answers on i_rgb, which is sampled one cycle after o_addr changes. There
// is no valid/ready pair. The table is assumed to be always ready.
module neopix_serializer #(
    parameter int CLK_RATE_HZ = 50_000_000,
    parameter int NUM_LEDS    = 41,
    parameter int RESET_US    = 60
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [7:0]  i_ledlevel,
    output logic [5:0]  o_addr,
    input  logic [23:0] i_rgb,
    output logic        o_neopix,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [1:0]  o_state
);

    // Bit timing in clock cycles. The 64-bit products avoid 32-bit overflow
    // at high clock rates.
    localparam int T_BIT   = CLK_RATE_HZ / 800_000;
    localparam int T0H     = int'((longint'(CLK_RATE_HZ) * 35) / 100_000_000);
    localparam int T1H     = int'((longint'(CLK_RATE_HZ) * 70) / 100_000_000);
    localparam int T_LATCH = (CLK_RATE_HZ / 1_000_000) * RESET_US;

    // One counter serves as prefetch step, bit tick and latch timer.
    localparam int CNT_MAX = (T_BIT > T_LATCH) ? T_BIT : T_LATCH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] TBIT_LAST   = CW'(T_BIT - 1);
    localparam logic [CW-1:0] TLATCH_LAST = CW'(T_LATCH - 1);
    localparam logic [CW-1:0] T0H_C       = CW'(T0H);
    localparam logic [CW-1:0] T1H_C       = CW'(T1H);
    localparam logic [5:0]    LAST_PIX    = 6'(NUM_LEDS - 1);
    localparam logic [6:0]    NUM_LEDS_W  = 7'(NUM_LEDS);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PREFETCH = 2'd1;
    localparam logic [1:0] SEND     = 2'd2;
    localparam logic [1:0] LATCH    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [5:0]    pix_q, pix_d;
    logic [5:0]    addr_q, addr_d;
    logic [23:0]   shift_q, shift_d;
    logic [23:0]   next_q, next_d;
    logic          neo_q, neo_d;

    logic [6:0]    pix_plus1;
    logic [6:0]    pix_plus2;
    logic [23:0]   scaled_rgb;

    // Per-channel brightness: (c * (level + 1)) >> 8.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] lvl);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, lvl} + 16'd1);
        return 8'(prod >> 8);
    endfunction

    assign pix_plus1  = {1'b0, pix_q} + 7'd1;
    assign pix_plus2  = {1'b0, pix_q} + 7'd2;
    // Reordered into wire order G, R, B so the shifter just sends bit 23 first.
    assign scaled_rgb = {scale8(i_rgb[15:8],  i_ledlevel),
                         scale8(i_rgb[23:16], i_ledlevel),
                         scale8(i_rgb[7:0],   i_ledlevel)};

    // Next-state logic for the frame sequencer, counters and shifters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        next_d  = next_q;
        case (state_q)
            IDLE: begin
                addr_d = 6'd0;
                if (i_enable) begin
                    state_d = PREFETCH;
                    cnt_d   = '0;
                end
            end
            PREFETCH: begin
                addr_d = 6'd0;
                if (cnt_q == '0) begin
                    cnt_d = CW'(1);
                end else begin
                    shift_d = scaled_rgb;
                    state_d = SEND;
                    cnt_d   = '0;
                    bit_d   = 5'd0;
                    pix_d   = 6'd0;
                    addr_d  = (NUM_LEDS > 1) ? 6'd1 : 6'd0;
                end
            end
            SEND: begin
                // Table answer for the address issued at the start of this pixel.
                if (cnt_q == CW'(1) && bit_q == 5'd0 && pix_plus1 < NUM_LEDS_W) begin
                    next_d = scaled_rgb;
                end
                if (cnt_q == TBIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd23) begin
                        bit_d = 5'd0;
                        if (pix_q == LAST_PIX) begin
                            state_d = LATCH;
                            addr_d  = 6'd0;
                        end else begin
                            pix_d   = pix_plus1[5:0];
                            shift_d = next_q;
                            if (pix_plus2 < NUM_LEDS_W) begin
                                addr_d = pix_plus2[5:0];
                            end
                        end
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin // LATCH
                addr_d = 6'd0;
                if (cnt_q == TLATCH_LAST) begin
                    cnt_d   = '0;
                    state_d = i_enable ? PREFETCH : IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
        // Line level is derived from next-state values so the pin is a clean flop.
        neo_d = (state_d == SEND) && (cnt_d < (shift_d[23] ? T1H_C : T0H_C));
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            next_q  <= '0;
            neo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            next_q  <= next_d;
            neo_q   <= neo_d;
        end
    end

    assign o_neopix     = neo_q;
    assign o_addr       = addr_q;
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = (state_q == LATCH) && (cnt_q == TLATCH_LAST);
    assign o_state      = state_q;

endmodule
